// File: rtl/disp_chan_scheduler.sv
// rtl/disp_chan_scheduler.sv - channel select / capture strobe scheduler for the 8-channel display mux
// Optional pause input is compiled in when DISP_SCHED_PAUSE_EN is defined.
module disp_chan_scheduler #(
  parameter int DWELL = 50_000_000,
  parameter int HOLD  = 100_000_000,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_auto,
  input  logic [2:0] sw_sel,
  input  logic [7:0] chan_mask,
  input  logic [7:0] req,
  input  logic       cpu_wr,
`ifdef DISP_SCHED_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] Test,
  output logic       EN,
  output logic       hold_active,
  output logic [2:0] grant_ch
);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rr_ptr;
  logic [2:0]       scan_ch;
  logic             ret_scan;

  logic [2:0] winner;
  logic [2:0] scan_next;
  logic       dwell_done;
  logic       hold_done;
  logic       freeze;

  // Offsets are walked from far to near so the nearest hit above the pointer is kept.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] r);
    logic [2:0] c;
    rr_pick = ptr;
    for (int i = 8; i >= 1; i--) begin
      c = ptr + 3'(i);
      if (r[c]) rr_pick = c;
    end
  endfunction

  function automatic logic [2:0] next_scan(input logic [2:0] cur, input logic [7:0] mask);
    logic [2:0] c;
    next_scan = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      c = cur + 3'(i);
      if (mask[c]) next_scan = c;
    end
  endfunction

`ifdef DISP_SCHED_PAUSE_EN
  assign freeze = pause && (state != ST_MANUAL);
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    winner     = rr_pick(rr_ptr, req);
    scan_next  = next_scan(Test, chan_mask);
    dwell_done = (cnt == CNT_W'(DWELL - 1));
    hold_done  = (cnt == CNT_W'(HOLD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_MANUAL;
      cnt         <= '0;
      rr_ptr      <= 3'd7;
      scan_ch     <= 3'd0;
      ret_scan    <= 1'b0;
      Test        <= 3'd0;
      EN          <= 1'b0;
      hold_active <= 1'b0;
      grant_ch    <= 3'd0;
    end else begin
      EN <= cpu_wr;
      if (state == ST_HOLD) begin
        if (!freeze) begin
          if (hold_done) begin
            hold_active <= 1'b0;
            cnt         <= '0;
            if (ret_scan) begin
              state <= ST_SCAN;
              Test  <= scan_ch;
            end else begin
              state <= ST_MANUAL;
              Test  <= sw_sel;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end else if (freeze) begin
        cnt <= cnt;
      end else if (req != 8'd0) begin
        // Grant outranks mode change and dwell expiry in the same cycle.
        state       <= ST_HOLD;
        Test        <= winner;
        grant_ch    <= winner;
        hold_active <= 1'b1;
        cnt         <= '0;
        rr_ptr      <= winner;
        ret_scan    <= mode_auto;
        scan_ch     <= Test;
      end else if (state == ST_MANUAL) begin
        cnt <= '0;
        if (mode_auto) state <= ST_SCAN;
        else           Test  <= sw_sel;
      end else if (!mode_auto) begin
        state <= ST_MANUAL;
        Test  <= sw_sel;
        cnt   <= '0;
      end else if (dwell_done) begin
        cnt  <= '0;
        Test <= scan_next;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_disp_chan_scheduler.sv
// tb/tb_disp_chan_scheduler.sv - randomized and directed bench for disp_chan_scheduler against a countdown model
module tb_disp_chan_scheduler;

  localparam int DWELL = 4;
  localparam int HOLD  = 3;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_auto;
  logic [2:0] sw_sel;
  logic [7:0] chan_mask;
  logic [7:0] req;
  logic       cpu_wr;
`ifdef DISP_SCHED_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] Test;
  logic       EN;
  logic       hold_active;
  logic [2:0] grant_ch;

  int n_vec = 0;
  int n_err = 0;

  disp_chan_scheduler #(.DWELL(DWELL), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode_auto(mode_auto), .sw_sel(sw_sel),
    .chan_mask(chan_mask), .req(req), .cpu_wr(cpu_wr),
`ifdef DISP_SCHED_PAUSE_EN
    .pause(pause),
`endif
    .Test(Test), .EN(EN), .hold_active(hold_active), .grant_ch(grant_ch)
  );

  always #5 clk = ~clk;

  // Reference: mode 0=manual 1=scan 2=hold, m_left = cycles remaining in the dwell/hold window.
  int m_st, m_left, m_rr, m_saved, m_ret;
  int e_test, e_grant, e_en, e_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_next(input int cur, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
    return 0;
  endfunction

  function automatic int pick_winner(input int p, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return p;
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = 0; m_rr = 7; m_saved = 0; m_ret = 0;
    e_test = 0; e_grant = 0; e_en = 0; e_hold = 0;
  endtask

  task automatic model_step();
    int pz;
    int w;
    pz = 0;
`ifdef DISP_SCHED_PAUSE_EN
    pz = int'(pause);
`endif
    e_en = int'(cpu_wr);
    if (m_st == 2) begin
      if (pz == 0) begin
        m_left--;
        if (m_left == 0) begin
          e_hold = 0;
          if (m_ret != 0) begin m_st = 1; e_test = m_saved; m_left = DWELL; end
          else begin m_st = 0; e_test = int'(sw_sel); end
        end
      end
    end else if (pz != 0 && m_st == 1) begin
      // frozen scan: nothing moves
    end else if (req != 8'd0) begin
      w = pick_winner(m_rr, req);
      m_saved = e_test; m_ret = int'(mode_auto);
      m_st = 2; m_left = HOLD; m_rr = w;
      e_test = w; e_grant = w; e_hold = 1;
    end else if (m_st == 0 && mode_auto) begin
      m_st = 1; m_left = DWELL;
    end else if (m_st == 1 && !mode_auto) begin
      m_st = 0; e_test = int'(sw_sel);
    end else if (m_st == 0) begin
      e_test = int'(sw_sel);
    end else begin
      m_left--;
      if (m_left == 0) begin e_test = pick_next(e_test, chan_mask); m_left = DWELL; end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("test", Test, e_test);
    chk("en", EN, e_en);
    chk("hold_active", hold_active, e_hold);
    chk("grant_ch", grant_ch, e_grant);
  endtask

  int scan_tbl[16] = '{0,0,0,0, 2,2,2,2, 7,7,7,7, 0,0,0,0};
  int gq[$];
  int h;
  logic prev_hold;

  initial begin
    rst = 1'b1; mode_auto = 1'b1; sw_sel = 3'd0; chan_mask = 8'h85; req = 8'h00; cpu_wr = 1'b0;
`ifdef DISP_SCHED_PAUSE_EN
    pause = 1'b0;
`endif
    model_reset();
    #12;
    chk("rst_test", Test, 0);
    chk("rst_en", EN, 0);
    chk("rst_hold", hold_active, 0);
    chk("rst_grant", grant_ch, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("scan_seq", Test, scan_tbl[i]);
    end
    chan_mask = 8'h00;
    repeat (8) cycle();
    chk("scan_empty", Test, 0);

    mode_auto = 1'b0; sw_sel = 3'd5;
    cycle();
    chk("manual_sel", Test, 5);
    cpu_wr = 1'b1; cycle(); chk("en_pulse", EN, 1);
    cpu_wr = 1'b0; cycle(); chk("en_after", EN, 0);
    cpu_wr = 1'b1; cycle(); cycle(); chk("en_b2b", EN, 1);
    cpu_wr = 1'b0; cycle();

    req = 8'b0001_0010;
    prev_hold = hold_active;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (hold_active && !prev_hold) gq.push_back(int'(grant_ch));
      prev_hold = hold_active;
    end
    chk("rr_count", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("rr_g0", gq[0], 1);
      chk("rr_g1", gq[1], 4);
      chk("rr_g2", gq[2], 1);
    end
    req = 8'h00;
    repeat (4) cycle();

    sw_sel = 3'd2; cycle();
    mode_auto = 1'b1; chan_mask = 8'h04;
    cycle(); cycle();
    req = 8'h40; cycle();
    chk("scan_grant", Test, 6);
    req = 8'h00;
    h = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (hold_active) h++;
    end
    chk("scan_hold_len", h, HOLD);
    chk("scan_return", Test, 2);

    req = 8'hFF; cycle();
    chk("pre_rst_hold", hold_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_test", Test, 0);
    chk("async_hold", hold_active, 0);
    chk("async_grant", grant_ch, 0);
    chk("async_en", EN, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; mode_auto = 1'b0;
    cycle();
    chk("first_grant", grant_ch, 0);
    req = 8'h00;
    repeat (4) cycle();

`ifdef DISP_SCHED_PAUSE_EN
    req = 8'h01; cycle();
    req = 8'h00;
    h = 1;
    for (int i = 0; i < 12; i++) begin
      pause = (i < 5);
      cycle();
      if (hold_active) h++;
    end
    pause = 1'b0;
    chk("pause_hold_len", h, HOLD + 5);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) mode_auto = ~mode_auto;
      sw_sel = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) chan_mask = 8'($urandom);
      req = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
      cpu_wr = 1'($urandom);
`ifdef DISP_SCHED_PAUSE_EN
      pause = ($urandom_range(9) == 0);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disp_chan_scheduler.md
Name: disp_chan_scheduler

Overview:
- Drives the 3-bit channel select (Test) and the capture strobe (EN) of the 8-channel 32-bit display multiplexer.
- Selects channels in one of three ways: manual from switches, auto-scan across enabled channels, or temporary round-robin override when a source raises a display request.
- Sits between the board switch/CPU-bus logic and the display mux feeding the 7-segment driver.

Parameters:
- DWELL, 50_000_000, clk cycles each channel is shown in auto-scan (>=2)
- HOLD, 100_000_000, clk cycles a granted request holds the display (>=1)
- CNT_W, 32, width of the dwell/hold counter; must hold max(DWELL, HOLD)

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- mode_auto  in  1  0 = manual select from sw_sel, 1 = auto-scan
- sw_sel  in  3  manual channel number
- chan_mask  in  8  channels included in auto-scan; bit i = channel i
- req  in  8  per-channel display request, level-sensitive
- cpu_wr  in  1  CPU wrote channel-0 display data
- Test  out  3  registered channel select to the mux
- EN  out  1  registered one-cycle capture strobe to the mux
- hold_active  out  1  high while a request grant owns the display
- grant_ch  out  3  channel currently granted; valid when hold_active

Behaviour:
- Reset values: Test=0, EN=0, hold_active=0, grant_ch=0, counter=0, round-robin pointer=7 (channel 0 wins first), scan channel=0. Reset is asynchronous and applies at any point, including mid-hold.
- EN: equals cpu_wr delayed one cycle, independent of state. Back-to-back cpu_wr gives back-to-back EN.
- States: MANUAL, SCAN, HOLD. After reset the state is set by mode_auto.
- MANUAL: Test <= sw_sel every cycle, one cycle latency. Counter is held at 0.
- SCAN: counter increments each cycle. When counter == DWELL-1:
  - counter <= 0
  - Test <= next channel above the current one (mod 8) whose chan_mask bit is 1, searching up to 8 positions
  - If chan_mask == 0, Test <= 0 and scanning continues idle.
  - If the current channel's mask bit is cleared mid-dwell, the channel still completes its dwell.
- Mode change: mode_auto toggling in MANUAL or SCAN switches state the next cycle.
  - Entering SCAN starts from the current Test with counter=0.
  - Entering MANUAL loads sw_sel.
- Request arbitration: evaluated only in MANUAL or SCAN, when req != 0.
  - Winner = first set bit strictly above the RR pointer, wrapping mod 8.
  - Next cycle: state=HOLD, Test=grant_ch=winner, hold_active=1, counter=0, RR pointer=winner.
  - The saved return state is MANUAL or SCAN per mode_auto at grant time; the saved scan channel is the Test value before the grant.
- HOLD: counter increments each cycle. When counter == HOLD-1 (exactly HOLD cycles with hold_active=1):
  - hold_active <= 0 and counter <= 0
  - Return to the saved state. SCAN restores the saved channel; MANUAL loads sw_sel.
- Request edge cases:
  - No preemption. req changes during HOLD are ignored until expiry, and requests dropping mid-hold do not shorten it.
  - A request still pending at expiry is arbitrated on the first non-HOLD cycle, so there is one return cycle between grants.
- Simultaneous events: request arbitration beats a dwell expiry or mode change in the same cycle. cpu_wr is never blocked.

Optional Feature:
- Macro DISP_SCHED_PAUSE_EN.
- When defined: adds input port pause (1 bit). While pause=1 in SCAN or HOLD:
  - the counter freezes
  - Test is unchanged
  - new requests are not arbitrated
  - EN still follows cpu_wr
- When not defined: no pause port, and the counter never freezes.

Test Plan (DWELL=4, HOLD=3):
- rst pulse mid-cycle with hold_active=1 -> outputs go to reset values immediately, without waiting for clk; first grant after release with req=8'hFF is channel 0.
- mode_auto=1, chan_mask=8'b1000_0101, no req -> Test sequence 0,2,7,0 with each value held 4 cycles; chan_mask=0 -> Test=0 steady.
- mode_auto=0, sw_sel=5 -> Test=5 one cycle later; cpu_wr pulse at cycle n -> EN=1 only at n+1.
- req=8'b0001_0010 held in MANUAL -> grant ch1 for 3 cycles, 1 return cycle, ch4 for 3 cycles, then back to ch1 (round-robin).
- SCAN on ch2 at counter=1, req[6] pulse of 1 cycle -> Test=6 with hold_active for exactly 3 cycles, then Test=2 with counter restarted at 0.
- With DISP_SCHED_PAUSE_EN: pause=1 for 5 cycles mid-hold -> hold_active lasts 3+5 cycles; without the macro the same stimulus cannot compile against a pause port, so the bench skips this case.
